pipelined_control: RTL and testbench

- Registered, parametrised successor to the combinational control decoder.
- Decodes each accepted instruction opcode into the datapath control word and registers it for the execute stage.
- Holds the word for multi-cycle multiply/divide and back-pressures fetch while it does.
- Supports pipeline stall, branch flush and a sticky HALT state. Sits between fetch/decode and the execute stage of the CPU.

---
 rtl/control_pkg.sv | 45 ++++
 rtl/control_decode.sv | 58 +++++
 rtl/pipelined_control.sv | 138 +++++++++++++
 tb/tb_pipelined_control.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared opcodes, control-field codes, FSM encoding and control-word layout
// for the registered control decoder.
package control_pkg;

    localparam logic [3:0] OP_ATYPE = 4'b1111;
    localparam logic [3:0] OP_LW    = 4'b1000;
    localparam logic [3:0] OP_SW    = 4'b1011;
    localparam logic [3:0] OP_BLT   = 4'b0100;
    localparam logic [3:0] OP_BGT   = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b0000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RW_NONE = 2'b00;
    localparam logic [1:0] RW_ONE  = 2'b01;
    localparam logic [1:0] RW_PAIR = 2'b10;

    localparam logic [1:0] JB_NONE   = 2'b00;
    localparam logic [1:0] JB_BRANCH = 2'b01;
    localparam logic [1:0] JB_JUMP   = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        MD   = 1'b1
    } state_t;

    typedef struct packed {
        logic       aluBType;
        logic       aluSrc;
        logic       signExtendFlag;
        logic       memRead;
        logic       memToReg;
        logic       memWrite;
        logic [1:0] aluControl;
        logic [1:0] regWrite;
        logic [1:0] jumpBranch;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: produces the control word, a legal flag,
// a HALT indication and the multiply/divide start request.
module control_decode
    import control_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                multiDiv,
    output ctrl_word_t          word,
    output logic                legal,
    output logic                halt,
    output logic                md_start
);

    always_comb begin
        word     = CTRL_NOP;
        legal    = 1'b1;
        halt     = 1'b0;
        md_start = 1'b0;
        // Any set bit above the 4-bit opcode field makes the instruction illegal.
        if ((opcode >> 4) != '0) begin
            legal = 1'b0;
        end else begin
            case (opcode[3:0])
                OP_ATYPE: begin
                    word.aluControl = ALU_FUNCT;
                    word.regWrite   = multiDiv ? RW_PAIR : RW_ONE;
                    md_start        = multiDiv;
                end
                OP_LW: begin
                    word.aluSrc         = 1'b1;
                    word.signExtendFlag = 1'b1;
                    word.memRead        = 1'b1;
                    word.memToReg       = 1'b1;
                    word.regWrite       = RW_ONE;
                    word.aluControl     = ALU_ADD;
                end
                OP_SW: begin
                    word.aluSrc         = 1'b1;
                    word.signExtendFlag = 1'b1;
                    word.memWrite       = 1'b1;
                    word.aluControl     = ALU_ADD;
                end
                OP_BLT, OP_BGT, OP_BEQ: begin
                    word.signExtendFlag = 1'b1;
                    word.aluControl     = ALU_SUB;
                    word.jumpBranch     = JB_BRANCH;
                    word.aluBType       = (opcode[3:0] != OP_BEQ);
                end
                OP_JMP:  word.jumpBranch = JB_JUMP;
                OP_HALT: halt = 1'b1;
                default: legal = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_control.sv
// Registered control decoder with multiply/divide hold, stall, flush and sticky HALT.
// Optional illegalTrap output enabled by defining CTRL_ILLEGAL_TRAP_EN.
module pipelined_control
    import control_pkg::*;
#(
    parameter int OPCODE_W  = 4,
    parameter int MD_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instrValid,
    output logic                instrReady,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                multiDiv,
    input  logic                stall,
    input  logic                flush,
    output logic                ctrlValid,
    output logic                aluBType,
    output logic                aluSrc,
    output logic                signExtendFlag,
    output logic                memRead,
    output logic                memToReg,
    output logic                memWrite,
    output logic [1:0]          aluControl,
    output logic [1:0]          regWrite,
    output logic [1:0]          jumpBranch,
    output logic                mdBusy,
    output logic                mdDone,
    output logic                halted
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegalTrap
`endif
);

    localparam int CNT_W = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    ctrl_word_t       dec_word;
    logic             dec_legal;
    logic             dec_halt;
    logic             dec_md_start;
    ctrl_word_t       ctrl_p1;
    logic             vld_p1;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             halt_q;
    logic             accept;

    control_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .opcode   (opcode),
        .multiDiv (multiDiv),
        .word     (dec_word),
        .legal    (dec_legal),
        .halt     (dec_halt),
        .md_start (dec_md_start)
    );

    assign instrReady = rst_n && (state == IDLE) && !stall && !halt_q && !flush;
    assign accept     = instrValid && instrReady;

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic trap_q;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            trap_q <= 1'b0;
        end else if (!stall) begin
            trap_q <= accept && !dec_legal;
        end
    end

    assign illegalTrap = trap_q;
`endif

    // p0 -> p1: decode result captured into the execute-facing register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_p1 <= CTRL_NOP;
            vld_p1  <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
            halt_q  <= 1'b0;
        end else if (flush) begin
            ctrl_p1 <= CTRL_NOP;
            vld_p1  <= 1'b0;
            state   <= IDLE;
            cnt     <= '0;
        end else if (!stall) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        ctrl_p1 <= dec_word;
                        // With the trap enabled an illegal opcode's NOP is not marked live.
                        vld_p1  <= dec_legal || !TRAP_EN;
                        if (dec_halt) halt_q <= 1'b1;
                        if (dec_md_start) begin
                            state <= MD;
                            cnt   <= CNT_W'(MD_CYCLES - 1);
                        end
                    end else begin
                        ctrl_p1 <= CTRL_NOP;
                        vld_p1  <= 1'b0;
                    end
                end
                MD: begin
                    if (cnt == '0) begin
                        state   <= IDLE;
                        ctrl_p1 <= CTRL_NOP;
                        vld_p1  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mdBusy         = (state == MD);
    assign mdDone         = mdBusy && (cnt == '0);
    assign halted         = halt_q;
    assign ctrlValid      = vld_p1;
    assign aluBType       = ctrl_p1.aluBType;
    assign aluSrc         = ctrl_p1.aluSrc;
    assign signExtendFlag = ctrl_p1.signExtendFlag;
    assign memRead        = ctrl_p1.memRead;
    assign memToReg       = ctrl_p1.memToReg;
    assign memWrite       = ctrl_p1.memWrite;
    assign aluControl     = ctrl_p1.aluControl;
    assign regWrite       = ctrl_p1.regWrite;
    assign jumpBranch     = ctrl_p1.jumpBranch;

endmodule

// File: tb/tb_pipelined_control.sv
// Scoreboard bench for pipelined_control: driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipelined_control;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    // Packed control word: {aluBType, aluSrc, signExt, memRead, memToReg, memWrite, alu[2], rw[2], jb[2]}
    localparam logic [11:0] W_NOP = 12'h000;
    localparam logic [11:0] W_LW  = 12'h784;
    localparam logic [11:0] W_SW  = 12'h640;
    localparam logic [11:0] W_BLT = 12'hA11;
    localparam logic [11:0] W_BEQ = 12'h211;
    localparam logic [11:0] W_JMP = 12'h002;
    localparam logic [11:0] W_AT  = 12'h024;
    localparam logic [11:0] W_MD  = 12'h028;

    logic       clk = 1'b0;
    logic       rst_n, instrValid, multiDiv, stall, flush;
    logic [3:0] opcode;
    logic       instrReady, ctrlValid, aluBType, aluSrc, signExtendFlag;
    logic       memRead, memToReg, memWrite, mdBusy, mdDone, halted;
    logic [1:0] aluControl, regWrite, jumpBranch;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegalTrap;
`endif

    typedef struct {
        string       nm;
        logic        rdy;
        logic        vld;
        logic [11:0] ctl;
        logic        busy;
        logic        done;
        logic        hlt;
        logic        trp;
    } exp_t;

    exp_t q[$];
    int   applied = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    pipelined_control #(.OPCODE_W(4), .MD_CYCLES(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instrValid     (instrValid),
        .instrReady     (instrReady),
        .opcode         (opcode),
        .multiDiv       (multiDiv),
        .stall          (stall),
        .flush          (flush),
        .ctrlValid      (ctrlValid),
        .aluBType       (aluBType),
        .aluSrc         (aluSrc),
        .signExtendFlag (signExtendFlag),
        .memRead        (memRead),
        .memToReg       (memToReg),
        .memWrite       (memWrite),
        .aluControl     (aluControl),
        .regWrite       (regWrite),
        .jumpBranch     (jumpBranch),
        .mdBusy         (mdBusy),
        .mdDone         (mdDone),
        .halted         (halted)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegalTrap    (illegalTrap)
`endif
    );

    // One cycle: inputs held for this cycle, expected outputs observed in this cycle.
    task automatic cy(input string nm, input bit rn, input bit iv, input logic [3:0] op,
                      input bit md, input bit st, input bit fl,
                      input bit rdy, input bit vld, input logic [11:0] ctl,
                      input bit busy, input bit done, input bit hlt, input bit trp);
        exp_t e;
        rst_n = rn; instrValid = iv; opcode = op; multiDiv = md; stall = st; flush = fl;
        e.nm = nm; e.rdy = rdy; e.vld = vld; e.ctl = ctl;
        e.busy = busy; e.done = done; e.hlt = hlt; e.trp = trp;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [11:0] act_ctl;
        logic        act_trp;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                act_ctl = {aluBType, aluSrc, signExtendFlag, memRead, memToReg, memWrite,
                           aluControl, regWrite, jumpBranch};
`ifdef CTRL_ILLEGAL_TRAP_EN
                act_trp = illegalTrap;
`else
                act_trp = 1'b0;
`endif
                applied++;
                if ({instrReady, ctrlValid, act_ctl, mdBusy, mdDone, halted, act_trp} !==
                    {e.rdy, e.vld, e.ctl, e.busy, e.done, e.hlt, e.trp}) begin
                    miscompares++;
                    $display("FAIL %s: got rdy=%b vld=%b ctl=%h busy=%b done=%b hlt=%b trap=%b, want rdy=%b vld=%b ctl=%h busy=%b done=%b hlt=%b trap=%b",
                             e.nm, instrReady, ctrlValid, act_ctl, mdBusy, mdDone, halted, act_trp,
                             e.rdy, e.vld, e.ctl, e.busy, e.done, e.hlt, e.trp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst_n = 1'b0; instrValid = 1'b1; opcode = 4'h8; multiDiv = 1'b0; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        //  name        rn iv op    md st fl  rdy vld ctl    bsy dn hlt trp
        cy("rst0",      0, 1, 4'h8, 0, 0, 0,  0,  0,  W_NOP, 0,  0, 0,  0);
        cy("rst1",      0, 1, 4'h8, 0, 0, 0,  0,  0,  W_NOP, 0,  0, 0,  0);
        cy("lw_acc",    1, 1, 4'h8, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("lw_out",    1, 1, 4'h4, 0, 0, 0,  1,  1,  W_LW,  0,  0, 0,  0);
        cy("blt_out",   1, 1, 4'h5, 0, 0, 0,  1,  1,  W_BLT, 0,  0, 0,  0);
        cy("bgt_out",   1, 1, 4'h6, 0, 0, 0,  1,  1,  W_BLT, 0,  0, 0,  0);
        cy("beq_out",   1, 1, 4'hB, 0, 0, 0,  1,  1,  W_BEQ, 0,  0, 0,  0);
        cy("sw_out",    1, 1, 4'hC, 0, 0, 0,  1,  1,  W_SW,  0,  0, 0,  0);
        cy("jmp_out",   1, 1, 4'hF, 0, 0, 0,  1,  1,  W_JMP, 0,  0, 0,  0);
        cy("atype_out", 1, 0, 4'h0, 0, 0, 0,  1,  1,  W_AT,  0,  0, 0,  0);
        cy("nop_out",   1, 0, 4'h0, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("stall_idl", 1, 1, 4'h8, 0, 1, 0,  0,  0,  W_NOP, 0,  0, 0,  0);
        cy("lw2_acc",   1, 1, 4'h8, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("stall_h1",  1, 0, 4'h0, 0, 1, 0,  0,  1,  W_LW,  0,  0, 0,  0);
        cy("stall_h2",  1, 0, 4'h0, 0, 1, 0,  0,  1,  W_LW,  0,  0, 0,  0);
        cy("stall_h3",  1, 0, 4'h0, 0, 0, 0,  1,  1,  W_LW,  0,  0, 0,  0);
        cy("drain",     1, 0, 4'h0, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);

        // Multiply/divide: 8 busy cycles, done on the 8th, then the next LW is accepted.
        cy("md_acc",    1, 1, 4'hF, 1, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        for (int i = 1; i <= 8; i++)
            cy($sformatf("md_c%0d", i), 1, 1, 4'h8, 0, 0, 0, 0, 1, W_MD, 1, (i == 8), 0, 0);
        cy("md_exit",   1, 1, 4'h8, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("md_next",   1, 0, 4'h0, 0, 0, 0,  1,  1,  W_LW,  0,  0, 0,  0);

        // Stall cycles 4..6 of a multiply/divide push mdDone out to cycle 11.
        cy("mds_acc",   1, 1, 4'hF, 1, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        for (int i = 1; i <= 11; i++)
            cy($sformatf("mds_c%0d", i), 1, 0, 4'h0, 0, (i >= 4 && i <= 6), 0,
               0, 1, W_MD, 1, (i == 11), 0, 0);
        cy("mds_exit",  1, 0, 4'h0, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);

        // Flush in cycle 3 aborts the multiply/divide without an mdDone pulse.
        cy("mdf_acc",   1, 1, 4'hF, 1, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("mdf_c1",    1, 0, 4'h0, 0, 0, 0,  0,  1,  W_MD,  1,  0, 0,  0);
        cy("mdf_c2",    1, 0, 4'h0, 0, 0, 0,  0,  1,  W_MD,  1,  0, 0,  0);
        cy("mdf_c3",    1, 1, 4'h8, 0, 0, 1,  0,  1,  W_MD,  1,  0, 0,  0);
        cy("mdf_after", 1, 0, 4'h0, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);

        // Flush and stall together: flush wins.
        cy("fs_acc",    1, 1, 4'h8, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("fs_both",   1, 1, 4'h8, 0, 1, 1,  0,  1,  W_LW,  0,  0, 0,  0);
        cy("fs_after",  1, 0, 4'h0, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);

        // Illegal opcode, then sticky HALT until reset.
        cy("ill_acc",   1, 1, 4'h3, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("ill_out",   1, 1, 4'h0, 0, 0, 0,  1,  !TRAP, W_NOP, 0, 0, 0, TRAP);
        cy("halt_out",  1, 1, 4'h8, 0, 0, 0,  0,  1,  W_NOP, 0,  0, 1,  0);
        cy("halt_dr",   1, 1, 4'h8, 0, 0, 0,  0,  0,  W_NOP, 0,  0, 1,  0);
        cy("halt_fl",   1, 1, 4'h8, 0, 0, 1,  0,  0,  W_NOP, 0,  0, 1,  0);
        cy("halt_rst",  0, 1, 4'h8, 0, 0, 0,  0,  0,  W_NOP, 0,  0, 1,  0);
        cy("post_rst",  1, 1, 4'h8, 0, 0, 0,  1,  0,  W_NOP, 0,  0, 0,  0);
        cy("post_lw",   1, 0, 4'h0, 0, 0, 0,  1,  1,  W_LW,  0,  0, 0,  0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
